// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream generator.
package rc4_pkg;

    localparam int SBOX_DEPTH = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        KSA   = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/rc4_sbox.sv
// 256-entry RC4 permutation held in flops. Two combinational read ports feed
// the swap (addr_a/addr_b); a third read port serves the output stage. Writes
// land only at the clock edge, so every read in a cycle sees the S-box as it
// was at the start of that cycle.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  byte_t addr_a,
    input  byte_t addr_b,
    input  logic  swap_en,
    output byte_t rd_a,
    output byte_t rd_b,
    input  byte_t addr_c,
    output byte_t rd_c
);

    byte_t mem [SBOX_DEPTH];

    // Identity permutation on reset, otherwise exchange S[a] and S[b].
    // With a == b both writes carry the same value, so order does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SBOX_DEPTH; k++) begin
                mem[k] <= byte_t'(k);
            end
        end else if (swap_en) begin
            mem[addr_a] <= mem[addr_b];
            mem[addr_b] <= mem[addr_a];
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_a = mem[addr_a];
        rd_b = mem[addr_b];
        rd_c = mem[addr_c];
    end

endmodule

// File: rtl/rc4_keystream.sv
// RC4 keystream generator: key load, key scheduling, then one keystream byte
// per request through a two-stage pipeline.
//
// state | meaning
// ------+--------------------------------------------------------------
// LOAD  | collecting KEY_LEN key bytes on key_valid
// KSA   | one key-scheduling swap per cycle, i = 0..255
// READY | PRGA: stage 1 swaps and registers t, stage 2 outputs S[t]
module rc4_keystream
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       key_valid,
    input  logic       ks_req,
    output logic [7:0] ks_out,
    output logic       ks_valid,
    output logic       init_done
);

    // Key index is sized to the key so the key array is addressed exactly.
    localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KIDX_W-1:0] KEY_LAST = KIDX_W'(KEY_LEN - 1);

    state_t state_q, state_d;

    byte_t             i_q, j_q, t_q;
    logic [KIDX_W-1:0] idx_q;
    logic              s2_valid_q;
    byte_t             key_mem [2**KIDX_W];

    byte_t addr_a, addr_b, addr_c;
    byte_t rd_a, rd_b, rd_c;
    byte_t key_byte, j_nxt;
    logic  swap_en;
    logic  prga_go;
    logic  key_last;

    rc4_sbox u_sbox (
        .clk     (clk),
        .rst     (rst),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .swap_en (swap_en),
        .rd_a    (rd_a),
        .rd_b    (rd_b),
        .addr_c  (addr_c),
        .rd_c    (rd_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (key_valid && key_last) state_d = KSA;
            KSA:     if (i_q == 8'hFF)          state_d = READY;
            READY:   state_d = READY;
            default: state_d = LOAD;
        endcase
    end

    // Port A addresses S[i] during KSA and S[i+1] during PRGA.
    always_comb begin
        key_byte = key_mem[idx_q];
        key_last = (idx_q == KEY_LAST);
        prga_go  = (state_q == READY) && ks_req;
        swap_en  = (state_q == KSA) || prga_go;
        addr_a   = (state_q == READY) ? (i_q + 8'd1) : i_q;
        addr_c   = t_q;
    end

    // New j depends on the port-A read; it becomes the port-B address.
    always_comb begin
        if (state_q == KSA) begin
            j_nxt = j_q + rd_a + key_byte;
        end else begin
            j_nxt = j_q + rd_a;
        end
        addr_b = j_nxt;
    end

    // Key storage; only written while loading, never reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == LOAD && key_valid) begin
            key_mem[idx_q] <= key_in;
        end
    end

    // Index registers, pipeline registers and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            t_q        <= 8'd0;
            idx_q      <= '0;
            s2_valid_q <= 1'b0;
            ks_out     <= 8'd0;
            ks_valid   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    i_q <= 8'd0;
                    j_q <= 8'd0;
                    if (key_valid) begin
                        idx_q <= key_last ? '0 : idx_q + KIDX_W'(1);
                    end
                end
                KSA: begin
                    i_q   <= i_q + 8'd1;
                    idx_q <= key_last ? '0 : idx_q + KIDX_W'(1);
                    if (i_q == 8'hFF) begin
                        j_q       <= 8'd0;
                        init_done <= 1'b1;
                    end else begin
                        j_q <= j_nxt;
                    end
                end
                READY: begin
                    if (prga_go) begin
                        i_q <= addr_a;
                        j_q <= j_nxt;
                        // Sum of the pre-swap pair equals the post-swap sum.
                        t_q <= rd_a + rd_b;
                    end
                end
                default: begin
                    i_q <= 8'd0;
                    j_q <= 8'd0;
                end
            endcase

            s2_valid_q <= prga_go;
            ks_valid   <= s2_valid_q;
            ks_out     <= s2_valid_q ? rd_c : 8'd0;
        end
    end

endmodule

// File: tb/tb_rc4_keystream.sv
// Directed bench for rc4_keystream: four instances with key lengths 3, 4, 6
// and 1, checked against published RC4 vectors and a software RC4 model.
module tb_rc4_keystream;

    localparam int N = 4;

    logic       clk;
    logic       rst_v       [N];
    logic [7:0] key_in_v    [N];
    logic       key_valid_v [N];
    logic       ks_req_v    [N];
    logic [7:0] ks_out_v    [N];
    logic       ks_valid_v  [N];
    logic       init_done_v [N];

    int n_checks;
    int n_fail;

    logic [7:0] exp_q [$];
    logic [7:0] kq    [$];

    rc4_keystream #(.KEY_LEN(3)) u_dut_len3 (
        .clk(clk), .rst(rst_v[0]), .key_in(key_in_v[0]), .key_valid(key_valid_v[0]),
        .ks_req(ks_req_v[0]), .ks_out(ks_out_v[0]), .ks_valid(ks_valid_v[0]),
        .init_done(init_done_v[0]));

    rc4_keystream #(.KEY_LEN(4)) u_dut_len4 (
        .clk(clk), .rst(rst_v[1]), .key_in(key_in_v[1]), .key_valid(key_valid_v[1]),
        .ks_req(ks_req_v[1]), .ks_out(ks_out_v[1]), .ks_valid(ks_valid_v[1]),
        .init_done(init_done_v[1]));

    rc4_keystream #(.KEY_LEN(6)) u_dut_len6 (
        .clk(clk), .rst(rst_v[2]), .key_in(key_in_v[2]), .key_valid(key_valid_v[2]),
        .ks_req(ks_req_v[2]), .ks_out(ks_out_v[2]), .ks_valid(ks_valid_v[2]),
        .init_done(init_done_v[2]));

    rc4_keystream #(.KEY_LEN(1)) u_dut_len1 (
        .clk(clk), .rst(rst_v[3]), .key_in(key_in_v[3]), .key_valid(key_valid_v[3]),
        .ks_req(ks_req_v[3]), .ks_out(ks_out_v[3]), .ks_valid(ks_valid_v[3]),
        .init_done(init_done_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst_v[d]       = 1'b1;
        key_valid_v[d] = 1'b0;
        ks_req_v[d]    = 1'b0;
        key_in_v[d]    = 8'h00;
        tick();
        tick();
        rst_v[d] = 1'b0;
    endtask

    // Reference RC4: KSA over kb, then n PRGA bytes into exp_q.
    task automatic model_gen(input logic [7:0] kb[$], input int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t, tmp;
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j      = j + s[a] + kb[a % kb.size()];
            tmp    = s[a];
            s[a]   = s[j];
            s[j]   = tmp;
        end
        i = 8'd0;
        j = 8'd0;
        exp_q.delete();
        for (int b = 0; b < n; b++) begin
            i    = i + 8'd1;
            j    = j + s[i];
            tmp  = s[i];
            s[i] = s[j];
            s[j] = tmp;
            t    = s[i] + s[j];
            exp_q.push_back(s[t]);
        end
    endtask

    // Feed key bytes, then wait for init_done. Returns cycles from the edge
    // that captured the last byte, and how many ks_valid pulses were seen.
    task automatic load_key(input int d, input logic [7:0] kb[$], input logic req_during,
                            output int ksa_cycles, output int stray);
        int cnt;
        stray         = 0;
        ks_req_v[d]   = req_during;
        for (int b = 0; b < kb.size(); b++) begin
            key_in_v[d]    = kb[b];
            key_valid_v[d] = 1'b1;
            tick();
            if (ks_valid_v[d] !== 1'b0) stray++;
        end
        key_valid_v[d] = 1'b0;
        key_in_v[d]    = 8'h00;
        cnt = 0;
        while (init_done_v[d] !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
            if (ks_valid_v[d] !== 1'b0) stray++;
        end
        ks_req_v[d] = 1'b0;
        ksa_cycles  = cnt;
        n_checks++;
        if (init_done_v[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_timeout dut%0d: init_done=%b after %0d cycles, required 1", d, init_done_v[d], cnt);
        end
    endtask

    // Issue nreq requests, one every 'period' cycles, and check every output
    // cycle against exp_q: valid exactly two edges after the request's edge.
    task automatic run_stream(input int d, input int period, input int nreq, input string name);
        int   issued;
        int   k;
        logic cur;
        logic prev;
        issued = 0;
        k      = 0;
        prev   = 1'b0;
        for (int c = 0; c < nreq * period + 3; c++) begin
            cur = (issued < nreq) && ((c % period) == 0);
            ks_req_v[d] = cur;
            if (cur) issued++;
            tick();
            n_checks++;
            if (ks_valid_v[d] !== prev) begin
                n_fail++;
                $display("FAIL %s ks_valid cycle %0d: got %b, required %b", name, c, ks_valid_v[d], prev);
            end
            n_checks++;
            if (prev) begin
                if (ks_out_v[d] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL %s ks_out byte %0d: got %02h, required %02h", name, k, ks_out_v[d], exp_q[k]);
                end
                k++;
            end else if (ks_out_v[d] !== 8'h00) begin
                n_fail++;
                $display("FAIL %s ks_out idle cycle %0d: got %02h, required 00", name, c, ks_out_v[d]);
            end
            prev = cur;
        end
        ks_req_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (ks_out_v[d] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_ks_out dut%0d: got %02h, required 00", d, ks_out_v[d]);
            end
            n_checks++;
            if (ks_valid_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ks_valid dut%0d: got %b, required 0", d, ks_valid_v[d]);
            end
            n_checks++;
            if (init_done_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_init_done dut%0d: got %b, required 0", d, init_done_v[d]);
            end
        end
    endtask

    task automatic test_key_continuous();
        int cyc, stray;
        kq = {8'h4B, 8'h65, 8'h79};
        load_key(0, kq, 1'b0, cyc, stray);
        n_checks++;
        if (cyc !== 256) begin
            n_fail++;
            $display("FAIL ksa_length: init_done after %0d cycles, required 256", cyc);
        end
        exp_q = {8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run_stream(0, 1, 10, "key_continuous");
        n_checks++;
        if (init_done_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_sticky: got %b, required 1", init_done_v[0]);
        end
    endtask

    task automatic test_wiki_spaced();
        int cyc, stray;
        kq = {8'h57, 8'h69, 8'h6B, 8'h69};
        load_key(1, kq, 1'b0, cyc, stray);
        exp_q = {8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
        run_stream(1, 3, 6, "wiki_spaced");
    endtask

    task automatic test_secret_req_ignored();
        int cyc, stray;
        kq = {8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
        load_key(2, kq, 1'b1, cyc, stray);
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL secret_req_in_load_ksa: %0d ks_valid pulses, required 0", stray);
        end
        tick();
        n_checks++;
        if (ks_valid_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL secret_after_init: ks_valid got %b, required 0", ks_valid_v[2]);
        end
        exp_q = {8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
        run_stream(2, 1, 8, "secret");
    endtask

    task automatic test_wrap_300();
        int cyc, stray;
        do_reset(0);
        kq = {8'h4B, 8'h65, 8'h79};
        load_key(0, kq, 1'b0, cyc, stray);
        model_gen(kq, 300);
        run_stream(0, 1, 300, "wrap_300");
    endtask

    task automatic test_reset_mid();
        int cyc, stray;
        do_reset(0);
        kq = {8'h4B, 8'h65, 8'h79};
        for (int b = 0; b < 3; b++) begin
            key_in_v[0]    = kq[b];
            key_valid_v[0] = 1'b1;
            tick();
        end
        key_valid_v[0] = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        rst_v[0] = 1'b1;
        tick();
        n_checks++;
        if ({ks_out_v[0], ks_valid_v[0], init_done_v[0]} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ksa: out=%02h valid=%b init=%b, required 00/0/0", ks_out_v[0], ks_valid_v[0], init_done_v[0]);
        end
        rst_v[0] = 1'b0;

        load_key(0, kq, 1'b0, cyc, stray);
        ks_req_v[0] = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        n_checks++;
        if (ks_valid_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_active: ks_valid got %b, required 1", ks_valid_v[0]);
        end
        rst_v[0] = 1'b1;
        tick();
        n_checks++;
        if ({ks_out_v[0], ks_valid_v[0], init_done_v[0]} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_mid_prga: out=%02h valid=%b init=%b, required 00/0/0", ks_out_v[0], ks_valid_v[0], init_done_v[0]);
        end
        rst_v[0]    = 1'b0;
        ks_req_v[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (ks_valid_v[0] !== 1'b0 || ks_out_v[0] !== 8'h00) begin
                n_fail++;
                $display("FAIL stale_after_rst cycle %0d: valid=%b out=%02h, required 0/00", c, ks_valid_v[0], ks_out_v[0]);
            end
        end

        load_key(0, kq, 1'b0, cyc, stray);
        exp_q = {8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run_stream(0, 1, 10, "reload_key");
    endtask

    task automatic test_keylen1();
        int cyc, stray;
        kq = {8'h00};
        load_key(3, kq, 1'b0, cyc, stray);
        n_checks++;
        if (cyc !== 256) begin
            n_fail++;
            $display("FAIL keylen1_ksa_length: %0d cycles, required 256", cyc);
        end
        model_gen(kq, 32);
        run_stream(3, 1, 32, "keylen1");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < N; d++) begin
            rst_v[d]       = 1'b1;
            key_in_v[d]    = 8'h00;
            key_valid_v[d] = 1'b0;
            ks_req_v[d]    = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < N; d++) rst_v[d] = 1'b0;

        test_reset();
        test_key_continuous();
        test_wiki_spaced();
        test_secret_req_ignored();
        test_wrap_300();
        test_reset_mid();
        test_keylen1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
